// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared widths, funct3 encodings and FSM state type for the data-memory responder
package rv_mem_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores, extraction/extension for loads, alignment and funct3 checks
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]      f3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata,
    output logic            align_err
);
    logic [XLEN-1:0] b_sh;
    logic [XLEN-1:0] h_sh;
    logic            illegal;
    // Size is taken from f3[1:0] on the store side; data is replicated so only the enabled lanes matter
    always_comb begin
        b_sh      = rword >> {addr_lo, 3'b000};
        h_sh      = rword >> {addr_lo[1], 4'b0000};
        illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        align_err = illegal || (((f3 == F3_H) || (f3 == F3_HU)) && addr_lo[0]) || ((f3 == F3_W) && (addr_lo != 2'b00));
        be        = (f3[1:0] == 2'b00) ? 4'b0001 << addr_lo :
                    (f3[1:0] == 2'b01) ? 4'b0011 << {addr_lo[1], 1'b0} :
                    (f3[1:0] == 2'b10) ? 4'b1111 : 4'b0000;
        wdata_sh  = (f3[1:0] == 2'b00) ? {4{wdata[7:0]}} :
                    (f3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
        rdata     = (f3 == F3_B)  ? {{24{b_sh[7]}}, b_sh[7:0]} :
                    (f3 == F3_BU) ? {24'd0, b_sh[7:0]} :
                    (f3 == F3_H)  ? {{16{h_sh[15]}}, h_sh[15:0]} :
                    (f3 == F3_HU) ? {16'd0, h_sh[15:0]} :
                    (f3 == F3_W)  ? rword : '0;
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready load/store responder with wait states over an internal word RAM
module data_mem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_f3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);
    localparam int AW = $clog2(DEPTH);
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   mem [DEPTH];
    logic [AW-1:0]     idx;
    logic              range_err;
    logic              align_err;
    logic              acc_err;
    logic              wr_en;
    logic [3:0]        be;
    logic [XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]   ld_data;

    assign idx       = addr_q[AW+1:2];
    assign range_err = |addr_q[XLEN-1:AW+2];
    assign acc_err   = align_err || range_err;
    assign wr_en     = (state_q == ACCESS) && we_q && !acc_err && !reset;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    mem_lane_align u_align (
        .f3        (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rword     (mem[idx]),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata     (ld_data),
        .align_err (align_err)
    );

    // Next-state and datapath: latch on accept, count wait states, resolve the access, hold the response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                we_d    = req_we;
                f3_d    = req_f3;
                wdata_d = req_wdata;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? ACCESS : WAIT;
            end
            ACCESS: begin
                rdata_d = (acc_err || we_q) ? '0 : ld_data;
                err_d   = acc_err;
                state_d = RESP;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM array write with per-byte enables; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
endmodule
